// File: rtl/mp_result_serializer.sv
// Result serializer for mp_adder: captures one (OPERAND_WIDTH+1)-bit sum on iDone
// and streams it LS word first over a registered valid/ready interface.
module mp_result_serializer #(
  parameter int OPERAND_WIDTH = 128,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iDone,
  input  logic [OPERAND_WIDTH:0] iRes,
  output logic [WORD_WIDTH-1:0]  oData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic                   oLast,
  output logic                   oBusy,
  output logic                   oOverrun
);

  localparam int NUM_WORDS = (OPERAND_WIDTH + WORD_WIDTH) / WORD_WIDTH;
  localparam int BUF_W     = NUM_WORDS * WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                r_state, w_state_nx;
  logic [BUF_W-1:0]      r_buf, w_buf_nx;
  logic [IDX_W-1:0]      r_idx, w_idx_nx;
  logic [WORD_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_valid, w_valid_nx;
  logic                  r_last, w_last_nx;
  logic                  r_overrun, w_overrun_nx;

  logic [BUF_W-1:0]      w_pad;
  logic [IDX_W-1:0]      w_idx_inc;
  logic                  w_last_accept;

  always_comb begin
    w_pad = '0;
    w_pad[OPERAND_WIDTH:0] = iRes;
  end

  assign w_idx_inc     = r_idx + 1'b1;
  assign w_last_accept = (r_state == SEND) && iReady && (r_idx == LAST_IDX);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_buf     <= w_buf_nx;
      r_idx     <= w_idx_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_last    <= w_last_nx;
      r_overrun <= w_overrun_nx;
    end
  end

  // r_buf holds only the words not yet presented; word 0 goes straight to r_data.
  always_comb begin
    w_state_nx   = r_state;
    w_buf_nx     = r_buf;
    w_idx_nx     = r_idx;
    w_data_nx    = r_data;
    w_valid_nx   = r_valid;
    w_last_nx    = r_last;
    w_overrun_nx = r_overrun;

    unique case (r_state)
      IDLE: begin
        if (iDone) begin
          w_buf_nx   = w_pad >> WORD_WIDTH;
          w_data_nx  = w_pad[WORD_WIDTH-1:0];
          w_idx_nx   = '0;
          w_valid_nx = 1'b1;
          w_last_nx  = (NUM_WORDS == 1);
          w_state_nx = SEND;
        end
      end
      SEND: begin
        if (w_last_accept) begin
          if (iDone) begin
            w_buf_nx  = w_pad >> WORD_WIDTH;
            w_data_nx = w_pad[WORD_WIDTH-1:0];
            w_idx_nx  = '0;
            w_last_nx = (NUM_WORDS == 1);
          end else begin
            w_buf_nx   = '0;
            w_data_nx  = '0;
            w_idx_nx   = '0;
            w_valid_nx = 1'b0;
            w_last_nx  = 1'b0;
            w_state_nx = IDLE;
          end
        end else begin
          if (iReady) begin
            w_data_nx = r_buf[WORD_WIDTH-1:0];
            w_buf_nx  = r_buf >> WORD_WIDTH;
            w_idx_nx  = w_idx_inc;
            w_last_nx = (w_idx_inc == LAST_IDX);
          end
          if (iDone) w_overrun_nx = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign oData    = r_data;
  assign oValid   = r_valid;
  assign oLast    = r_last;
  assign oBusy    = (r_state == SEND);
  assign oOverrun = r_overrun;

endmodule

// File: tb/tb_mp_result_serializer.sv
// Scoreboard bench for mp_result_serializer at default parameters (5 x 32-bit words).
module tb_mp_result_serializer;

  localparam int OW = 128;
  localparam int WW = 32;
  localparam int NW = 5;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          iDone = 1'b0;
  logic [OW:0]   iRes = '0;
  logic [WW-1:0] oData;
  logic          oValid;
  logic          iReady = 1'b0;
  logic          oLast;
  logic          oBusy;
  logic          oOverrun;

  typedef struct packed {
    logic [WW-1:0] d;
    logic          l;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [OW:0] RES_A = 129'h1_02020202_02020202_02020202_09090908;
  localparam logic [OW:0] RES_F = 129'h0_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [OW:0] RES_B = 129'h1_DEADBEEF_12345678_CAFEF00D_A5A55A5A;
  localparam logic [OW:0] RES_1 = 129'h0_00000000_00000000_00000000_00000001;

  mp_result_serializer #(.OPERAND_WIDTH(OW), .WORD_WIDTH(WW)) dut (
    .iClk(iClk), .iRst(iRst), .iDone(iDone), .iRes(iRes),
    .oData(oData), .oValid(oValid), .iReady(iReady),
    .oLast(oLast), .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  // Accepts happen at the next rising edge with the inputs stable here.
  always @(negedge iClk) begin
    if (oValid === 1'b1 && iReady === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got data=%h last=%b, expected no word", oData, oLast);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (oData !== e.d || oLast !== e.l) begin
          bad++;
          $display("FAIL word: got data=%h last=%b, expected data=%h last=%b", oData, oLast, e.d, e.l);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic push_result(input logic [OW:0] res);
    logic [OW:0] t;
    exp_t e;
    t = res;
    for (int w = 0; w < NW; w++) begin
      e.d = t[WW-1:0];
      e.l = (w == NW - 1);
      q.push_back(e);
      t = t >> WW;
    end
  endtask

  task automatic send_result(input logic [OW:0] res);
    iDone = 1'b1;
    iRes  = res;
    push_result(res);
    tick();
    iDone = 1'b0;
    iRes  = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(q.size() == 0 && oValid === 1'b0) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (!(q.size() == 0 && oValid === 1'b0)) begin
      bad++;
      $display("FAIL %s_drain: got pending=%0d oValid=%b, expected pending=0 oValid=0", name, q.size(), oValid);
    end
  endtask

  task automatic do_reset();
    iReady = 1'b0;
    iDone  = 1'b0;
    iRst   = 1'b1;
    tick();
    iRst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    total++;
    if ({oData, oValid, oLast, oBusy, oOverrun} !== '0) begin
      bad++;
      $display("FAIL reset_state: got data=%h v=%b l=%b b=%b ov=%b, expected all 0",
               oData, oValid, oLast, oBusy, oOverrun);
    end
  endtask

  task automatic test_basic();
    iReady = 1'b1;
    send_result(RES_A);
    for (int i = 0; i < NW; i++) begin
      total++;
      if (oValid !== 1'b1 || oBusy !== 1'b1) begin
        bad++;
        $display("FAIL basic_valid%0d: got v=%b b=%b, expected v=1 b=1", i, oValid, oBusy);
      end
      tick();
    end
    total++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== '0) begin
      bad++;
      $display("FAIL basic_idle: got v=%b b=%b d=%h, expected v=0 b=0 d=0", oValid, oBusy, oData);
    end
    wait_drain("basic");
  endtask

  task automatic test_backpressure();
    iReady = 1'b1;
    send_result(RES_A);
    tick();
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (oData !== 32'h02020202 || oValid !== 1'b1 || oLast !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got d=%h v=%b l=%b, expected d=02020202 v=1 l=0", i, oData, oValid, oLast);
      end
      tick();
    end
    iReady = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_overrun();
    iReady = 1'b1;
    send_result(RES_F);
    tick();
    tick();
    iReady = 1'b0;
    iDone  = 1'b1;
    iRes   = 129'h5;
    tick();
    iDone = 1'b0;
    total++;
    if (oOverrun !== 1'b1 || oData !== 32'hFFFFFFFF || oValid !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got ov=%b d=%h v=%b, expected ov=1 d=ffffffff v=1", oOverrun, oData, oValid);
    end
    iReady = 1'b1;
    wait_drain("overrun");
    total++;
    if (oOverrun !== 1'b1 || oBusy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sticky: got ov=%b b=%b, expected ov=1 b=0", oOverrun, oBusy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    iReady = 1'b1;
    send_result(RES_A);
    for (int i = 0; i < NW - 1; i++) tick();
    total++;
    if (oLast !== 1'b1 || oData !== 32'h00000001) begin
      bad++;
      $display("FAIL b2b_lastword: got l=%b d=%h, expected l=1 d=00000001", oLast, oData);
    end
    send_result(RES_B);
    total++;
    if (oValid !== 1'b1 || oData !== 32'hA5A55A5A || oOverrun !== 1'b0 || oLast !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: got v=%b d=%h ov=%b l=%b, expected v=1 d=a5a55a5a ov=0 l=0",
               oValid, oData, oOverrun, oLast);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    iReady = 1'b1;
    send_result(RES_A);
    tick();
    tick();
    do_reset();
    total++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oData !== '0 || oOverrun !== 1'b0 || oLast !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: got v=%b b=%b d=%h ov=%b l=%b, expected all 0",
               oValid, oBusy, oData, oOverrun, oLast);
    end
    iReady = 1'b1;
    send_result(RES_B);
    total++;
    if (oData !== 32'hA5A55A5A || oValid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_restart: got d=%h v=%b, expected d=a5a55a5a v=1", oData, oValid);
    end
    wait_drain("reset_mid");
  endtask

  task automatic test_carry_zero();
    iReady = 1'b1;
    send_result(RES_1);
    wait_drain("carry_zero");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_carry_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
